// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand sequencer: ALU mode encoding,
// sequencer state encoding and bit positions inside the captured flag vector.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_NOT = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;
    localparam logic [2:0] ALU_EQ  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT_B = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // out_flags is ordered {zero, overflow, carry}
    localparam int FLAG_ZERO     = 2;
    localparam int FLAG_OVERFLOW = 1;
    localparam int FLAG_CARRY    = 0;

endpackage

// File: rtl/alu_seq.sv
// Operand sequencer and result register in front of an external ALU.
// Define ALU_SEQ_CHAIN_EN to add the in_chain port (single-beat chained operations).
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_mode,
`ifdef ALU_SEQ_CHAIN_EN
    input  logic             in_chain,
`endif
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_mode,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    input  logic             alu_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [2:0]       out_flags,
    output logic [7:0]       op_count
);

    state_t state;
    state_t state_next;
    logic   accept;
    logic   load_a;
    logic   load_b;
    logic   chain_load;

    // Handshake qualifiers come straight from the state register so neither
    // stream has a combinational path through this block.
    assign in_ready  = (state == ST_IDLE) || (state == ST_WAIT_B);
    assign out_valid = (state == ST_HOLD);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_next = state;
        load_a     = 1'b0;
        load_b     = 1'b0;
        chain_load = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
`ifdef ALU_SEQ_CHAIN_EN
                    if (in_chain) begin
                        load_b     = 1'b1;
                        chain_load = 1'b1;
                        state_next = ST_EXEC;
                    end else begin
                        load_a     = 1'b1;
                        state_next = ST_WAIT_B;
                    end
`else
                    load_a     = 1'b1;
                    state_next = ST_WAIT_B;
`endif
                end
            end
            ST_WAIT_B: begin
                if (accept) begin
                    load_b     = 1'b1;
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // The ALU is combinational, so its outputs have settled by the end of EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_mode   <= '0;
            out_result <= '0;
            out_flags  <= '0;
            op_count   <= '0;
        end else begin
            state <= state_next;
            if (load_a) begin
                alu_a <= in_data;
            end
            if (chain_load) begin
                alu_a <= out_result;
            end
            if (load_b) begin
                alu_b    <= in_data;
                alu_mode <= in_mode;
            end
            if (state == ST_EXEC) begin
                out_result               <= alu_result;
                out_flags[FLAG_ZERO]     <= alu_zero;
                out_flags[FLAG_OVERFLOW] <= alu_overflow;
                out_flags[FLAG_CARRY]    <= alu_carry;
                op_count                 <= op_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq with a behavioural 4-bit ALU in the parent's role.
// Define ALU_SEQ_CHAIN_EN to also exercise chained operations.
module tb_alu_seq;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [2:0] in_mode;
`ifdef ALU_SEQ_CHAIN_EN
    logic       in_chain;
`endif
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_mode;
    logic [3:0] alu_result;
    logic       alu_zero;
    logic       alu_overflow;
    logic       alu_carry;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_result;
    logic [2:0] out_flags;
    logic [7:0] op_count;

    typedef struct packed {
        logic [3:0] result;
        logic [2:0] flags;
        logic [7:0] count;
    } exp_t;

    exp_t       sb[$];
    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_count = 8'd0;
    logic [4:0] wide;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_mode     (in_mode),
`ifdef ALU_SEQ_CHAIN_EN
        .in_chain    (in_chain),
`endif
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_mode    (alu_mode),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .alu_overflow(alu_overflow),
        .alu_carry   (alu_carry),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_flags   (out_flags),
        .op_count    (op_count)
    );

    // Stand-in ALU; carry on subtract is the carry out of a + ~b + 1
    always_comb begin
        wide         = '0;
        alu_result   = '0;
        alu_overflow = 1'b0;
        alu_carry    = 1'b0;
        case (alu_mode)
            ALU_ADD: begin
                wide         = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result   = wide[3:0];
                alu_carry    = wide[4];
                alu_overflow = (alu_a[3] == alu_b[3]) && (wide[3] != alu_a[3]);
            end
            ALU_SUB: begin
                wide         = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
                alu_result   = wide[3:0];
                alu_carry    = wide[4];
                alu_overflow = (alu_a[3] != alu_b[3]) && (wide[3] != alu_a[3]);
            end
            ALU_NOT: alu_result = ~alu_a;
            ALU_AND: alu_result = alu_a & alu_b;
            ALU_OR:  alu_result = alu_a | alu_b;
            ALU_XOR: alu_result = alu_a ^ alu_b;
            ALU_SLT: alu_result = {3'b000, $signed(alu_a) < $signed(alu_b)};
            ALU_EQ:  alu_result = {3'b000, alu_a == alu_b};
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == 4'd0);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Each output handshake retires the oldest expected result.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_result", sb.size(), 1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("out_result", out_result, e.result);
                checkOutput("out_flags", out_flags, e.flags);
                checkOutput("op_count", op_count, e.count);
            end
        end
    end

    task automatic pushExpected(input logic [3:0] result, input logic [2:0] flags);
        exp_count = exp_count + 8'd1;
        sb.push_back({result, flags, exp_count});
    endtask

    task automatic waitAccept();
        logic rdy;
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        checkOutput("beat_accepted", ok, 1);
    endtask

    task automatic applyStimulus(input logic [3:0] data, input logic [2:0] mode);
        in_data  = data;
        in_mode  = mode;
`ifdef ALU_SEQ_CHAIN_EN
        in_chain = 1'b0;
`endif
        in_valid = 1'b1;
        waitAccept();
    endtask

    task automatic doOp(input logic [3:0] a, input logic [3:0] b, input logic [2:0] mode,
                        input logic [3:0] res, input logic [2:0] flags);
        applyStimulus(a, mode);
        pushExpected(res, flags);
        applyStimulus(b, mode);
        checkOutput("exec_valid_low", out_valid, 0);
        @(posedge clk);
        #1;
        checkOutput("valid_latency", out_valid, 1);
        checkOutput("hold_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        checkOutput("idle_after_handshake", in_ready, 1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = '0;
`ifdef ALU_SEQ_CHAIN_EN
        in_chain  = 1'b0;
`endif
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_alu_ops", {alu_a, alu_b, alu_mode}, 0);
        checkOutput("reset_outputs", {out_result, out_flags, op_count}, 0);
        rst = 1'b0;

        doOp(4'b0111, 4'b0001, ALU_ADD, 4'b1000, 3'b010);
        doOp(4'b0011, 4'b0011, ALU_SUB, 4'b0000, 3'b101);
        doOp(4'b1110, 4'b0001, ALU_SLT, 4'b0001, 3'b000);

        // Backpressure: the result must sit untouched while in_valid is ignored
        out_ready = 1'b0;
        applyStimulus(4'b1010, ALU_XOR);
        pushExpected(4'b1100, 3'b000);
        applyStimulus(4'b0110, ALU_XOR);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 4'b1111;
        in_mode  = ALU_ADD;
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp_out_valid", out_valid, 1);
            checkOutput("bp_out_result", out_result, 4'b1100);
            checkOutput("bp_out_flags", out_flags, 3'b000);
            checkOutput("bp_in_ready", in_ready, 0);
            checkOutput("bp_alu_ops", {alu_a, alu_b, alu_mode}, {4'b1010, 4'b0110, ALU_XOR});
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_idle_in_ready", in_ready, 1);
        checkOutput("bp_idle_out_valid", out_valid, 0);

        // Reset in WAIT_B discards the half-loaded operation
        applyStimulus(4'b0101, ALU_ADD);
        checkOutput("wait_b_alu_a", alu_a, 4'b0101);
        checkOutput("wait_b_in_ready", in_ready, 1);
        rst = 1'b1;
        #2;
        checkOutput("mid_rst_in_ready", in_ready, 1);
        checkOutput("mid_rst_out_valid", out_valid, 0);
        checkOutput("mid_rst_alu_ops", {alu_a, alu_b, alu_mode}, 0);
        checkOutput("mid_rst_outputs", {out_result, out_flags, op_count}, 0);
        exp_count = 8'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("post_rst_op_count", op_count, 0);

        doOp(4'b1100, 4'b1010, ALU_AND, 4'b1000, 3'b000);
        doOp(4'b0101, 4'b1111, ALU_NOT, 4'b1010, 3'b000);
        doOp(4'b0110, 4'b0110, ALU_EQ,  4'b0001, 3'b000);
        doOp(4'b0001, 4'b0100, ALU_OR,  4'b0101, 3'b000);
        doOp(4'b1001, 4'b1000, ALU_ADD, 4'b0001, 3'b011);

`ifdef ALU_SEQ_CHAIN_EN
        doOp(4'b0111, 4'b0001, ALU_ADD, 4'b1000, 3'b010);
        pushExpected(4'b0111, 3'b011);
        in_data  = 4'b0001;
        in_mode  = ALU_SUB;
        in_chain = 1'b1;
        in_valid = 1'b1;
        waitAccept();
        in_chain = 1'b0;
        checkOutput("chain_alu_a", alu_a, 4'b1000);
        checkOutput("chain_exec_valid_low", out_valid, 0);
        @(posedge clk);
        #1;
        checkOutput("chain_valid_latency", out_valid, 1);
        @(posedge clk);
        #1;
        checkOutput("chain_idle", in_ready, 1);
`endif

        for (int i = 0; i < 10 && sb.size() != 0; i++) begin
            @(posedge clk);
        end
        checkOutput("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
